// File: rtl/dm_access_unit.sv
// Data memory access stage: word-addressed RAM behind an IDLE/WAIT/COMPLETE
// handshake with a fixed number of wait states before each access commits.
module dm_access_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] DMADDR,
  input  logic [DATA_W-1:0] DMDATAIN,
  input  logic              MEMRD,
  input  logic              MEMWR,
  output logic [DATA_W-1:0] DMDATAOUT,
  output logic              BUSY,
  output logic              DONE
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMPLETE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [DATA_W-1:0] dout_reg;
  logic [IW-1:0]     idx_reg;
  logic [DATA_W-1:0] data_reg;
  logic              wr_reg;
  logic              req;
  logic              commit;

  logic [DATA_W-1:0] ram [DEPTH];

  // Upper address bits are deliberately ignored: addresses wrap modulo DEPTH.
  generate
    if (ADDR_W > IW) begin : g_addr_hi
      logic unused_addr_bits;
      assign unused_addr_bits = ^DMADDR[ADDR_W-1:IW];
    end
  endgenerate

  assign req    = MEMRD | MEMWR;
  assign commit = (state_reg == S_WAIT) && (cnt_reg == '0);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          state_next = S_WAIT;
          cnt_next   = CW'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        if (cnt_reg == '0) state_next = S_COMPLETE;
        else               cnt_next   = cnt_reg - CW'(1);
      end
      S_COMPLETE: state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
    // Flags are decoded from the next state so they come straight out of flops.
    busy_next = (state_next == S_WAIT);
    done_next = (state_next == S_COMPLETE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dout_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      if (commit && !wr_reg) dout_reg <= ram[idx_reg];
    end
  end

  // Request capture; a simultaneous read+write is treated as a write.
  always_ff @(posedge clk) begin
    if (state_reg == S_IDLE && req) begin
      idx_reg  <= DMADDR[IW-1:0];
      data_reg <= DMDATAIN;
      wr_reg   <= MEMWR;
    end
  end

  // RAM contents survive reset; reset only blocks an in-flight commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && wr_reg) ram[idx_reg] <= data_reg;
  end

  assign DMDATAOUT = dout_reg;
  assign BUSY      = busy_reg;
  assign DONE      = done_reg;

endmodule
